// File: rtl/player_link_pkg.sv
// player_link_pkg: shared types, constants and frame helpers for the framed
// position link (TX framer in player_link, RX parser in player_link_rx).
package player_link_pkg;

  localparam int unsigned FRAME_LEN = 6;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned SEQ_W     = 6;
  localparam int unsigned POS_W     = 12;
  localparam int unsigned LVL_W     = 2;

  typedef enum logic {
    IDLE,
    SEND
  } tx_state_t;

  typedef enum logic [2:0] {
    HUNT,
    P1,
    P2,
    P3,
    P4,
    CHK
  } rx_state_t;

  // Player position payload carried by one frame.
  typedef struct packed {
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
    logic [LVL_W-1:0] level;
  } pos_t;

  // Frame check byte: XOR of the four payload bytes.
  function automatic logic [7:0] checksum(input logic [7:0] b1,
                                          input logic [7:0] b2,
                                          input logic [7:0] b3,
                                          input logic [7:0] b4);
    return b1 ^ b2 ^ b3 ^ b4;
  endfunction

  // Byte idx (0..5) of the frame carrying position p and sequence number seq.
  function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] idx,
                                            input logic [7:0]       header,
                                            input pos_t             p,
                                            input logic [SEQ_W-1:0] seq);
    logic [7:0] b1, b2, b3, b4;
    logic [7:0] res;
    b1 = p.x[7:0];
    b2 = {p.y[3:0], p.x[11:8]};
    b3 = p.y[11:4];
    b4 = {p.level, seq};
    case (idx)
      3'd0:    res = header;
      3'd1:    res = b1;
      3'd2:    res = b2;
      3'd3:    res = b3;
      3'd4:    res = b4;
      3'd5:    res = checksum(b1, b2, b3, b4);
      default: res = 8'h00;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/player_link_rx.sv
// player_link_rx: parses the incoming byte stream into frames, validates the
// checksum and holds the last good remote position with a link timeout.
//   clk, rst          : clock, synchronous active-low reset
//   rx_data, rx_valid : byte strobe from the UART receiver
//   remote            : last good remote position (registered)
//   remote_valid      : good frame seen within TIMEOUT_CYCLES (registered)
//   frame_err         : saturating count of checksum failures (registered)
module player_link_rx
  import player_link_pkg::*;
#(
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 32'd2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output pos_t       remote,
  output logic       remote_valid,
  output logic [7:0] frame_err
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

  rx_state_t        state_q, state_d;
  logic [7:0]       p1_q, p2_q, p3_q, p4_q;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             chk_c, good_c, bad_c;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= HUNT;
    else      state_q <= state_d;
  end

  // Next state: only a header byte leaves HUNT; payload bytes are taken blindly.
  always_comb begin
    state_d = state_q;
    if (rx_valid) begin
      case (state_q)
        HUNT:    if (rx_data == HEADER) state_d = P1;
        P1:      state_d = P2;
        P2:      state_d = P3;
        P3:      state_d = P4;
        P4:      state_d = CHK;
        CHK:     state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end
  end

  // Frame verdict strobes and next timeout count.
  always_comb begin
    chk_c  = rx_valid && (state_q == CHK);
    good_c = chk_c && (rx_data == checksum(p1_q, p2_q, p3_q, p4_q));
    bad_c  = chk_c && !good_c;
    tmo_d  = tmo_q;
    if (good_c)                tmo_d = '0;
    else if (tmo_q != TMO_MAX) tmo_d = tmo_q + TMO_W'(1);
  end

  // Payload capture, remote outputs, error counter and timeout counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      p1_q         <= '0;
      p2_q         <= '0;
      p3_q         <= '0;
      p4_q         <= '0;
      tmo_q        <= '0;
      remote       <= '0;
      remote_valid <= 1'b0;
      frame_err    <= '0;
    end else begin
      if (rx_valid) begin
        case (state_q)
          P1:      p1_q <= rx_data;
          P2:      p2_q <= rx_data;
          P3:      p3_q <= rx_data;
          P4:      p4_q <= rx_data;
          default: ;
        endcase
      end
      tmo_q <= tmo_d;
      if (good_c) begin
        remote.x     <= {p2_q[3:0], p1_q};
        remote.y     <= {p3_q, p2_q[7:4]};
        remote.level <= p4_q[7:6];
        remote_valid <= 1'b1;
      end else if (tmo_d == TMO_MAX) begin
        // Link lost: position holds, only the valid flag drops.
        remote_valid <= 1'b0;
      end
      if (bad_c && (frame_err != 8'hFF)) frame_err <= frame_err + 8'd1;
    end
  end

endmodule

// File: rtl/player_link.sv
// player_link: framed, checksummed position link between the game controller
// and the byte-level UART. TX snapshots the local position on request and sends
// a 6-byte frame; RX (player_link_rx) decodes frames from the remote player.
//   clk, rst                        : 100 MHz clock, synchronous active-low reset
//   send_req                        : one-cycle request to send local state
//   x_local, y_local, level_local   : local player state
//   tx_data, tx_valid, tx_ready     : byte stream to the UART transmitter
//   rx_data, rx_valid               : byte strobe from the UART receiver
//   x_remote, y_remote, level_remote: last good remote state
//   remote_valid, frame_err         : link status and checksum error count
module player_link
  import player_link_pkg::*;
#(
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 32'd2_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             send_req,
  input  logic [POS_W-1:0] x_local,
  input  logic [POS_W-1:0] y_local,
  input  logic [LVL_W-1:0] level_local,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [POS_W-1:0] x_remote,
  output logic [POS_W-1:0] y_remote,
  output logic [LVL_W-1:0] level_remote,
  output logic             remote_valid,
  output logic [7:0]       frame_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  tx_state_t        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_inc_c;
  logic [SEQ_W-1:0] seq_q, seq_d;
  pos_t             snap_q;
  logic             pending_q, pending_d;
  logic             tx_valid_d;
  logic [7:0]       tx_data_d;
  logic             accept_c, last_c, start_c, chain_c, load_c;
  pos_t             remote;

  // Handshake decode shared by the next-state and output logic.
  always_comb begin
    idx_inc_c = idx_q + IDX_W'(1);
    accept_c  = tx_valid && tx_ready;
    last_c    = (state_q == SEND) && accept_c && (idx_q == LAST_IDX);
    start_c   = (state_q == IDLE) && (send_req || pending_q);
    // A queued (or coincident) request starts the next frame straight after B5.
    chain_c   = last_c && (pending_q || send_req);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_c) state_d = SEND;
      SEND:    if (last_c && !chain_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered TX outputs and datapath.
  always_comb begin
    idx_d      = idx_q;
    seq_d      = seq_q;
    pending_d  = pending_q;
    load_c     = 1'b0;
    tx_valid_d = tx_valid;
    tx_data_d  = tx_data;
    case (state_q)
      IDLE: begin
        tx_valid_d = 1'b0;
        tx_data_d  = 8'h00;
        if (start_c) begin
          load_c     = 1'b1;
          idx_d      = '0;
          pending_d  = 1'b0;
          tx_valid_d = 1'b1;
          tx_data_d  = HEADER;
        end
      end
      SEND: begin
        if (last_c) begin
          seq_d     = seq_q + SEQ_W'(1);
          pending_d = 1'b0;
          if (chain_c) begin
            load_c     = 1'b1;
            idx_d      = '0;
            tx_valid_d = 1'b1;
            tx_data_d  = HEADER;
          end else begin
            tx_valid_d = 1'b0;
            tx_data_d  = 8'h00;
          end
        end else begin
          // One-deep queue: a request while the flag is set is dropped.
          if (send_req) pending_d = 1'b1;
          if (accept_c) begin
            idx_d     = idx_inc_c;
            tx_data_d = frame_byte(idx_inc_c, HEADER, snap_q, seq_q);
          end
        end
      end
      default: begin
        tx_valid_d = 1'b0;
        tx_data_d  = 8'h00;
      end
    endcase
  end

  // TX datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q     <= '0;
      seq_q     <= '0;
      pending_q <= 1'b0;
      snap_q    <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
    end else begin
      idx_q     <= idx_d;
      seq_q     <= seq_d;
      pending_q <= pending_d;
      tx_valid  <= tx_valid_d;
      tx_data   <= tx_data_d;
      if (load_c) begin
        snap_q.x     <= x_local;
        snap_q.y     <= y_local;
        snap_q.level <= level_local;
      end
    end
  end

  player_link_rx #(
    .HEADER         (HEADER),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .remote       (remote),
    .remote_valid (remote_valid),
    .frame_err    (frame_err)
  );

  assign x_remote     = remote.x;
  assign y_remote     = remote.y;
  assign level_remote = remote.level;

endmodule

// File: doc/player_link.md
# player_link

Framed position link between the local game controller and the byte-level UART, replacing the three independent raw byte channels with one checksummed stream. On each send request it snapshots the local player position and level and emits a 6-byte frame. In parallel it parses incoming bytes, validates frames and holds the last good remote position for the remote-player and finish-screen drawing stages. Runs in the 100 MHz controller domain.

## Interface
- `HEADER`, default 8'hA5: frame start byte.
- `TIMEOUT_CYCLES`, default 2_000_000: cycles without a good frame before the link is declared lost (20 ms at 100 MHz).
- `clk` in 1: system clock, 100 MHz domain.
- `rst` in 1: one clock; reset is synchronous and active-low.
- `send_req` in 1: one-cycle request to transmit the current local state.
- `x_local` in 12: local x position.
- `y_local` in 12: local y position.
- `level_local` in 2: local level.
- `tx_data` out 8: byte to UART transmitter.
- `tx_valid` out 1: `tx_data` valid.
- `tx_ready` in 1: UART transmitter can accept a byte.
- `rx_data` in 8: byte from UART receiver.
- `rx_valid` in 1: one-cycle strobe, `rx_data` valid.
- `x_remote` out 12: last good remote x.
- `y_remote` out 12: last good remote y.
- `level_remote` out 2: last good remote level.
- `remote_valid` out 1: a good frame was received within `TIMEOUT_CYCLES`.
- `frame_err` out 8: saturating count of checksum failures.

## Operation
- Frame bytes B0..B5:
  - B0 = `HEADER`.
  - B1 = x[7:0].
  - B2 = {y[3:0], x[11:8]}.
  - B3 = y[11:4].
  - B4 = {level[1:0], seq[5:0]}.
  - B5 = B1^B2^B3^B4.
- `seq` is a 6-bit TX counter, incremented per frame sent, wraps 63→0.
- TX FSM states:
  - IDLE: on `send_req` (or pending flag set), latch x/y/level into a snapshot register, → SEND with index 0.
  - SEND: `tx_valid`=1, `tx_data`=B[index]. When `tx_valid && tx_ready`, advance the index. After B5 is accepted, → IDLE.
- `send_req` during SEND sets a one-deep pending flag. Further requests while the flag is set are dropped. The pending frame starts the cycle after B5 is accepted, using values latched at that moment.
- `tx_data` and `tx_valid` stay stable while `tx_valid && !tx_ready`.
- RX FSM states:
  - HUNT: only `HEADER` advances to P1. Other bytes are ignored.
  - P1–P4: store any byte unconditionally. An in-payload byte equal to `HEADER` is treated as data.
  - CHK: if the received byte equals the XOR of P1–P4, update the remote outputs and `remote_valid`; otherwise increment `frame_err` (saturate at 255). Either way → HUNT.
- RX ignores the received `seq` other than for the checksum.
- Timeout counter:
  - Cleared on a good frame.
  - Otherwise increments, saturating at `TIMEOUT_CYCLES`.
  - Reaching `TIMEOUT_CYCLES` clears `remote_valid`; the remote position outputs hold their last values.
- TX and RX are fully independent; simultaneous `send_req` and `rx_valid` are both serviced in the same cycle.

## Timing
- Reset (`rst`=0 at a clock edge), all outputs and state:
  - Outputs `tx_valid`=0, `tx_data`=0, `x_remote`=0, `y_remote`=0, `level_remote`=0, `remote_valid`=0, `frame_err`=0.
  - `seq`=0, timeout counter 0, both FSMs in IDLE/HUNT, pending flag cleared.
- Reset mid-frame abandons the frame; no partial bytes are emitted afterwards.
- `send_req` at edge N: `tx_valid`=1 with B0 at edge N+1.
- Minimum frame time is 6 cycles with `tx_ready` held high.
- Good CHK byte with `rx_valid` at edge N: remote outputs and `remote_valid` update at edge N+1.
- Failed CHK byte at edge N: `frame_err` increments at edge N+1.

## Structure
- Shared package `player_link_pkg`:
  - Frame length constant (6).
  - `tx_state_t` {IDLE, SEND}.
  - `rx_state_t` {HUNT, P1, P2, P3, P4, CHK}.
  - Byte-index width.
  - A checksum function.
- One sub-module, `player_link_rx`, holds the RX FSM, payload registers, checksum check and timeout counter.
- The top level holds the TX FSM, snapshot register, pending flag and `seq` counter.
- Top-level integration: outputs feed the remote-player drawing stage and the finish screen; `x_local`, `y_local` and `level_local` come from the game controller.

## Test plan
- Send, unstalled: x=0x123, y=0x456, level=2, `send_req`, `tx_ready`=1 → bytes A5,23,61,45,80,87 on consecutive cycles; `seq` becomes 1.
- Backpressure and pending: `tx_ready` toggling 1/0 with a second `send_req` mid-frame → bytes held stable while stalled; exactly two frames sent, the second starts right after B5; a third request during the pending window is dropped.
- RX good frame with leading garbage: feed 00,A5,23,61,45,80,87 → `x_remote`=0x123, `y_remote`=0x456, `level_remote`=2, `remote_valid`=1, `frame_err`=0.
- RX bad checksum: feed A5,23,61,45,80,88 → remote outputs unchanged, `frame_err`=1; the next good frame is accepted.
- Timeout: after a good frame, no bytes for `TIMEOUT_CYCLES` (set to 100 in sim) → `remote_valid` falls on cycle 100 and the position outputs hold.
- Reset mid-TX (after B2) and mid-RX (after P2) → all outputs at reset values; a fresh frame afterwards sends and decodes correctly.
